// File: rtl/rsa_pkg.sv
// Shared types for the RSA datapath: exponentiator FSM states and a latency
// helper that benches use to predict when a modular exponentiation completes.
package rsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REDUCE = 3'd1,
        ST_MUL    = 3'd2,
        ST_SQR    = 3'd3,
        ST_FINISH = 3'd4
    } exp_state_e;

    // Edges from accepted start to done for a given modulus/exponent pair.
    function automatic int mod_exp_latency(input int width,
                                           input logic [63:0] modulus,
                                           input logic [63:0] exponent);
        int pc;
        int bl;
        pc = 0;
        bl = 0;
        if (modulus <= 64'd1) return 2;
        for (int i = 0; i < 64; i++) begin
            if (exponent[i]) begin
                pc = pc + 1;
                bl = i + 1;
            end
        end
        return 1 + (width + 1) * (1 + pc + ((bl > 0) ? bl - 1 : 0));
    endfunction

endpackage

// File: rtl/mod_mult_serial.sv
// Bit-serial interleaved modular multiplier: p = x*y mod m, MSB-first over y.
// One load edge followed by WIDTH iteration edges; requires x < m and m > 1.
module mod_mult_serial #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] m,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] m_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q;

    logic [WIDTH:0]   dbl;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] p_d;

    // p stays below m between iterations, so each step needs at most one
    // subtraction after doubling and one after adding x.
    always_comb begin
        dbl = {p_q, 1'b0};
        if (dbl >= {1'b0, m_q}) dbl = dbl - {1'b0, m_q};
        sum = dbl + (y_q[WIDTH-1] ? {1'b0, x_q} : '0);
        if (sum >= {1'b0, m_q}) sum = sum - {1'b0, m_q};
        p_d = sum[WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q    <= '0;
            x_q    <= '0;
            y_q    <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                p_q   <= '0;
                x_q   <= x;
                y_q   <= y;
                m_q   <= m;
                cnt_q <= CW'(WIDTH);
            end else if (cnt_q != '0) begin
                p_q    <= p_d;
                y_q    <= {y_q[WIDTH-2:0], 1'b0};
                cnt_q  <= cnt_q - CW'(1);
                done_q <= (cnt_q == CW'(1));
            end
        end
    end

    assign done = done_q;
    assign p    = p_q;

endmodule

// File: rtl/seq_mod_exp.sv
// Right-to-left square-and-multiply modular exponentiator built around one
// shared serial modular multiplier; operations are chained back to back.
module seq_mod_exp
    import rsa_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] exponent,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             error
);

    exp_state_e       state_q;
    logic             launch_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] e_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] result_q;

    exp_state_e       nxt_op;
    logic [WIDTH-1:0] b_d;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] e_d;

    logic             mm_start;
    logic [WIDTH-1:0] mm_x;
    logic [WIDTH-1:0] mm_y;
    logic             mm_done;
    logic [WIDTH-1:0] mm_p;

    mod_mult_serial #(
        .WIDTH(WIDTH)
    ) u_mult (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (mm_start),
        .x      (mm_x),
        .y      (mm_y),
        .m      (m_q),
        .done   (mm_done),
        .p      (mm_p)
    );

    // Scan decision on multiplier completion. The exponent's LSB is cleared
    // after a multiply, so the following scan sees it as "square or finish";
    // this never squares past the most-significant set bit.
    always_comb begin
        b_d   = b_q;
        acc_d = acc_q;
        if (state_q == ST_REDUCE || state_q == ST_SQR) b_d = mm_p;
        if (state_q == ST_MUL) acc_d = mm_p;

        if (e_q == '0) begin
            nxt_op = ST_FINISH;
            e_d    = e_q;
        end else if (e_q[0]) begin
            nxt_op = ST_MUL;
            e_d    = {e_q[WIDTH-1:1], 1'b0};
        end else begin
            nxt_op = ST_SQR;
            e_d    = e_q >> 1;
        end

        mm_start = 1'b0;
        mm_x     = '0;
        mm_y     = '0;
        if (launch_q) begin
            mm_start = (m_q > WIDTH'(1));
            mm_x     = WIDTH'(1);
            mm_y     = b_q;
        end else if (mm_done && nxt_op != ST_FINISH) begin
            mm_start = 1'b1;
            mm_x     = (nxt_op == ST_MUL) ? acc_d : b_d;
            mm_y     = b_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            launch_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            b_q      <= '0;
            m_q      <= '0;
            e_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // done_q gates out the done cycle so a held start waits.
                    if (start && !done_q) begin
                        b_q      <= base;
                        m_q      <= modulus;
                        e_q      <= exponent;
                        acc_q    <= WIDTH'(1);
                        launch_q <= 1'b1;
                        state_q  <= ST_REDUCE;
                    end
                end
                ST_REDUCE, ST_MUL, ST_SQR: begin
                    if (launch_q) begin
                        launch_q <= 1'b0;
                        busy_q   <= 1'b1;
                        if (m_q <= WIDTH'(1)) state_q <= ST_FINISH;
                    end else if (mm_done) begin
                        b_q   <= b_d;
                        acc_q <= acc_d;
                        e_q   <= e_d;
                        if (nxt_op == ST_FINISH) begin
                            result_q <= acc_d;
                            error_q  <= 1'b0;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            state_q <= nxt_op;
                        end
                    end
                end
                ST_FINISH: begin
                    // Only degenerate moduli (0 or 1) land here.
                    result_q <= '0;
                    error_q  <= (m_q == '0);
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign error  = error_q;

endmodule

// File: tb/tb_seq_mod_exp.sv
// Scoreboard bench for seq_mod_exp at WIDTH 8, 16 and 64 against an
// arithmetic modular-power reference.
module tb_seq_mod_exp;

    typedef struct {
        int          id;
        logic [63:0] res;
        logic        err;
        int          acc;
        int          lat;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        st8, bz8, dn8, er8;
    logic [7:0]  b8, e8, m8, r8;
    logic        st16, bz16, dn16, er16;
    logic [15:0] b16, e16, m16, r16;
    logic        st64, bz64, dn64, er64;
    logic [63:0] b64, e64, m64, r64;

    seq_mod_exp #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(st8), .base(b8), .modulus(m8),
        .exponent(e8), .busy(bz8), .done(dn8), .result(r8), .error(er8));
    seq_mod_exp #(.WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(st16), .base(b16), .modulus(m16),
        .exponent(e16), .busy(bz16), .done(dn16), .result(r16), .error(er16));
    seq_mod_exp #(.WIDTH(64)) dut64 (
        .clk(clk), .reset_n(reset_n), .start(st64), .base(b64), .modulus(m64),
        .exponent(e64), .busy(bz64), .done(dn64), .result(r64), .error(er64));

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          req = 0;
    int          ack = 0;
    sb_t         sb[$];
    int          hold_at[3] = '{-1, -1, -1};
    logic [63:0] hold_val[3];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic get_busy(input int id);
        case (id)
            0: return bz8;
            1: return bz16;
            default: return bz64;
        endcase
    endfunction
    function automatic logic get_done(input int id);
        case (id)
            0: return dn8;
            1: return dn16;
            default: return dn64;
        endcase
    endfunction
    function automatic logic get_err(input int id);
        case (id)
            0: return er8;
            1: return er16;
            default: return er64;
        endcase
    endfunction
    function automatic logic [63:0] get_res(input int id);
        case (id)
            0: return {56'd0, r8};
            1: return {48'd0, r16};
            default: return r64;
        endcase
    endfunction

    // Reference: base^e mod m by plain binary powering on 128-bit integers.
    function automatic logic [63:0] ref_pow(input logic [63:0] b, input logic [63:0] e,
                                            input logic [63:0] m);
        logic [127:0] r, bb, mm;
        if (m == 64'd0) return 64'd0;
        mm = {64'd0, m};
        r  = 128'd1 % mm;
        bb = {64'd0, b} % mm;
        for (int i = 0; i < 64; i++) begin
            if (e[i]) r = (r * bb) % mm;
            bb = (bb * bb) % mm;
        end
        return r[63:0];
    endfunction

    // One reduction, one multiply per set bit, one square per bit below the top.
    function automatic int ref_lat(input logic [63:0] e, input logic [63:0] m, input int w);
        int pc, bl;
        if (m <= 64'd1) return 2;
        pc = $countones(e);
        bl = 0;
        for (int i = 0; i < 64; i++) if (e[i]) bl = i + 1;
        return 1 + (w + 1) * (1 + pc + ((bl > 0) ? bl - 1 : 0));
    endfunction

    // Monitor: sole owner of the check counters and of scoreboard pops.
    always @(negedge clk) begin : monitor
        int  e;
        sb_t h;
        e = cyc - 1;
        if (req != ack) begin
            for (int id = 0; id < 3; id++) begin
                checks++;
                if (get_busy(id) || get_done(id) || get_err(id) || get_res(id) != 64'd0) begin
                    errors++;
                    $display("FAIL idle_state inst%0d: busy=%0b done=%0b error=%0b result=%0h, required all 0",
                             id, get_busy(id), get_done(id), get_err(id), get_res(id));
                end
            end
            ack++;
        end
        for (int id = 0; id < 3; id++) begin
            if (hold_at[id] == e) begin
                checks++;
                if (get_res(id) != hold_val[id]) begin
                    errors++;
                    $display("FAIL result_hold inst%0d: result=%0h, required %0h",
                             id, get_res(id), hold_val[id]);
                end
                hold_at[id] = -1;
            end
        end
        if (!reset_n) begin
            sb.delete();
            for (int id = 0; id < 3; id++) hold_at[id] = -1;
        end else begin
            for (int id = 0; id < 3; id++) begin
                if (get_done(id)) begin
                    if (sb.size() == 0 || sb[0].id != id) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_done inst%0d: done=1 at edge %0d, required no done", id, e);
                    end else begin
                        h = sb.pop_front();
                        checks++;
                        if (get_res(id) != h.res || get_err(id) != h.err) begin
                            errors++;
                            $display("FAIL result inst%0d: result=%0h error=%0b, required result=%0h error=%0b",
                                     id, get_res(id), get_err(id), h.res, h.err);
                        end
                        checks++;
                        if (e != h.acc + h.lat || get_busy(id)) begin
                            errors++;
                            $display("FAIL done_timing inst%0d: done at latency %0d busy=%0b, required latency %0d busy=0",
                                     id, e - h.acc, get_busy(id), h.lat);
                        end
                        hold_at[id]  = e + 3;
                        hold_val[id] = h.res;
                    end
                end
            end
            if (sb.size() > 0) begin
                h = sb[0];
                if (e == h.acc + 1 || (h.lat > 2 && e == h.acc + h.lat - 1)) begin
                    checks++;
                    if (!get_busy(h.id)) begin
                        errors++;
                        $display("FAIL busy inst%0d: busy=0 at edge +%0d, required 1", h.id, e - h.acc);
                    end
                end
                if (e > h.acc + h.lat + 2) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout inst%0d: no done by edge +%0d, required done at +%0d",
                             h.id, e - h.acc, h.lat);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic issue(input int id, input logic [63:0] b, input logic [63:0] e,
                         input logic [63:0] m, input logic [63:0] r, input logic err,
                         input int lat);
        sb_t item;
        @(negedge clk);
        case (id)
            0: begin b8 = b[7:0]; e8 = e[7:0]; m8 = m[7:0]; st8 = 1'b1; end
            1: begin b16 = b[15:0]; e16 = e[15:0]; m16 = m[15:0]; st16 = 1'b1; end
            default: begin b64 = b; e64 = e; m64 = m; st64 = 1'b1; end
        endcase
        item.id  = id;
        item.res = r;
        item.err = err;
        item.acc = cyc;
        item.lat = lat;
        sb.push_back(item);
        @(negedge clk);
        st8  = 1'b0;
        st16 = 1'b0;
        st64 = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20000; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d transactions outstanding, required 0", sb.size());
            $fatal(1, "scoreboard did not drain");
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_op(input int id, input int w, input bit small_e);
        logic [63:0] mk, b, e, m;
        mk = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        b = {$urandom, $urandom} & mk;
        e = {$urandom, $urandom} & mk;
        m = {$urandom, $urandom} & mk;
        if (small_e) e = e & 64'hFF;
        issue(id, b, e, m, ref_pow(b, e, m), (m == 64'd0), ref_lat(e, m, w));
        wait_idle();
    endtask

    initial begin
        reset_n = 1'b0;
        st8 = 1'b0; st16 = 1'b0; st64 = 1'b0;
        b8 = '0; e8 = '0; m8 = '0;
        b16 = '0; e16 = '0; m16 = '0;
        b64 = '0; e64 = '0; m64 = '0;
        repeat (3) @(negedge clk);
        req++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        req++;
        repeat (2) @(negedge clk);

        issue(1, 4, 13, 497, 445, 1'b0, 120);          wait_idle();
        issue(1, 2, 10, 1000, 24, 1'b0, 103);          wait_idle();
        issue(1, 65535, 2, 65521, 196, 1'b0, 52);      wait_idle();
        issue(1, 9, 0, 7, 1, 1'b0, 18);                wait_idle();
        issue(1, 123, 45, 1, 0, 1'b0, 2);              wait_idle();
        issue(1, 123, 45, 0, 0, 1'b1, 2);              wait_idle();

        // Fermat run with a competing start held while busy.
        issue(1, 3, 65520, 65521, 1, 1'b0, 477);
        repeat (10) @(negedge clk);
        b16 = 16'd2; e16 = 16'd5; m16 = 16'd11; st16 = 1'b1;
        repeat (20) @(negedge clk);
        st16 = 1'b0;
        wait_idle();

        // Abort a long run at edge 40, then a fresh run must complete cleanly.
        issue(1, 7, 16'hBEEF, 60000, ref_pow(7, 16'hBEEF, 60000), 1'b0, ref_lat(16'hBEEF, 60000, 16));
        repeat (40) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        req++;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(1, 5, 3, 13, 8, 1'b0, 69);               wait_idle();

        for (int i = 0; i < 20; i++) rand_op(0, 8, 1'b0);
        for (int i = 0; i < 5; i++) rand_op(1, 16, 1'b0);
        rand_op(2, 64, 1'b1);
        for (int i = 0; i < 4; i++) rand_op(2, 64, 1'b0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
